// File: rtl/count_spi_pkg.sv
// count_spi_pkg: shared constants and helpers for the count_spi_tx slice.
//   - FSM state encoding (IDLE/LOAD/SHIFT/DRAIN)
//   - CRC-8 polynomial and single-bit CRC update helper
//   - minimum host sclk divider and bit-counter width helper
package count_spi_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [7:0] CRC8_POLY    = 8'h07;
  localparam int         MIN_SCLK_DIV = 8;

  // Bit counter must cover the longest frame (data plus optional CRC byte).
  function automatic int bitcnt_w(input int data_w);
    return $clog2(data_w + 8);
  endfunction

  // One MSB-first step of CRC-8 with polynomial CRC8_POLY.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    if (fb) begin
      return {crc[6:0], 1'b0} ^ CRC8_POLY;
    end else begin
      return {crc[6:0], 1'b0};
    end
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an asynchronous pin, followed by
// one edge-detect flop producing single-cycle rise/fall pulses.
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset (chain loads RST_VAL so that no
//           spurious edge is reported when reset releases)
//   din   - asynchronous pin
//   rise  - one-cycle pulse after a synchronised 0->1 transition
//   fall  - one-cycle pulse after a synchronised 1->0 transition
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchroniser chain plus the edge-detect history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RST_VAL}};
      prev_r <= RST_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign rise = sync_r[STAGES-1] & ~prev_r;
  assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/count_spi_tx.sv
// count_spi_tx: SPI responder (mode 0, MSB first) returning photon-count
// snapshots. A chip-select assertion captures cnt once (snap pulse), then the
// snapshot is shifted out on miso, one bit per host sclk falling edge.
// Optional macro COUNT_SPI_CRC_EN appends a CRC-8 (poly 0x07, init 0x00,
// MSB first, no final XOR) of the snapshot after the data bits.
// Ports:
//   clk50Mhz    - system clock
//   rst         - asynchronous active-low reset
//   cnt         - live count input
//   sclk, cs_n  - asynchronous host SPI clock and active-low chip select
//   miso        - registered serial data
//   miso_oe     - pad output enable, high while a frame is in progress
//   snap        - one-cycle pulse in the cycle cnt is captured
//   busy        - frame in progress
//   frame_done  - one-cycle pulse: frame ended after all bits were shifted
//   short_frame - one-cycle pulse: cs_n rose before all bits were shifted
import count_spi_pkg::*;

module count_spi_tx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk50Mhz,
  input  logic              rst,
  input  logic [DATA_W-1:0] cnt,
  input  logic              sclk,
  input  logic              cs_n,
  output logic              miso,
  output logic              miso_oe,
  output logic              snap,
  output logic              busy,
  output logic              frame_done,
  output logic              short_frame
);

`ifdef COUNT_SPI_CRC_EN
  localparam int FRAME_W = DATA_W + 8;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int BCW = bitcnt_w(DATA_W);

  logic               sclk_rise_s;
  logic               sclk_fall_s;
  logic               cs_rise_s;
  logic               cs_fall_s;
  logic [1:0]         state_r;
  logic [FRAME_W-1:0] shreg_r;
  logic [FRAME_W-1:0] frame_s;
  logic [BCW-1:0]     bitcnt_r;
  logic               miso_r;
  logic               miso_oe_r;
  logic               snap_r;
  logic               busy_r;
  logic               frame_done_r;
  logic               short_frame_r;
  logic               sync_unused_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk   (clk50Mhz),
    .rst_n (rst),
    .din   (sclk),
    .rise  (sclk_rise_s),
    .fall  (sclk_fall_s)
  );

  // cs_n idles high, so its chain resets high to avoid a false cs_fall.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk50Mhz),
    .rst_n (rst),
    .din   (cs_n),
    .rise  (cs_rise_s),
    .fall  (cs_fall_s)
  );

  // Mode 0 responder only acts on sclk falling edges.
  assign sync_unused_s = sclk_rise_s;

`ifdef COUNT_SPI_CRC_EN
  logic [7:0] crc_s;

  // Whole-snapshot CRC evaluated combinationally from cnt during LOAD.
  always_comb begin
    crc_s = 8'h00;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      crc_s = crc8_update(crc_s, cnt[i]);
    end
    frame_s = {cnt, crc_s};
  end
`else
  assign frame_s = cnt;
`endif

  // Frame FSM with registered outputs. miso holds the bit currently on the
  // wire and shreg_r holds the bits still to come, so each shift moves the
  // top of shreg_r onto miso.
  always_ff @(posedge clk50Mhz or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      shreg_r       <= '0;
      bitcnt_r      <= '0;
      miso_r        <= 1'b0;
      miso_oe_r     <= 1'b0;
      snap_r        <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      short_frame_r <= 1'b0;
    end else begin
      snap_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      short_frame_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_r   <= ST_LOAD;
            snap_r    <= 1'b1;
            busy_r    <= 1'b1;
            miso_oe_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          // cnt is sampled only here; later changes cannot reach the frame.
          {miso_r, shreg_r} <= {frame_s, 1'b0};
          bitcnt_r          <= '0;
          if (cs_rise_s) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
            miso_r        <= 1'b0;
            short_frame_r <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // cs_rise wins over a simultaneous sclk_fall.
          if (cs_rise_s) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
            miso_r        <= 1'b0;
            short_frame_r <= 1'b1;
          end else if (sclk_fall_s) begin
            shreg_r  <= {shreg_r[FRAME_W-2:0], 1'b0};
            bitcnt_r <= bitcnt_r + BCW'(1);
            if (bitcnt_r == BCW'(FRAME_W - 1)) begin
              state_r <= ST_DRAIN;
              miso_r  <= 1'b0;
            end else begin
              state_r <= ST_SHIFT;
              miso_r  <= shreg_r[FRAME_W-1];
            end
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DRAIN: begin
          if (cs_rise_s) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            miso_oe_r    <= 1'b0;
            miso_r       <= 1'b0;
            frame_done_r <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          miso_oe_r <= 1'b0;
          miso_r    <= 1'b0;
        end
      endcase
    end
  end

  assign miso        = miso_r;
  assign miso_oe     = miso_oe_r;
  assign snap        = snap_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign short_frame = short_frame_r;

endmodule
